// File: rtl/vedic_mul_pkg.sv
// rtl/vedic_mul_pkg.sv - shared state encoding, digit constants and index-width helpers for the vedic_mul sequencer
package vedic_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int PP_W    = 8;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Digit counter width; a single-digit operand still needs one bit.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/multiply4x4.sv
// rtl/multiply4x4.sv - combinational 4x4 unsigned Vedic multiplier core built from four 2x2 blocks
module multiply4x4
  import vedic_mul_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);

  // Urdhva-tiryagbhyam 2x2: vertical and crosswise bit products with half-adders.
  function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
    logic [3:0] r;
    logic       cross_a;
    logic       cross_b;
    logic       carry;
    logic       top;
    r[0]    = u[0] & v[0];
    cross_a = u[1] & v[0];
    cross_b = u[0] & v[1];
    r[1]    = cross_a ^ cross_b;
    carry   = cross_a & cross_b;
    top     = u[1] & v[1];
    r[2]    = top ^ carry;
    r[3]    = top & carry;
    return r;
  endfunction

  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;

  // Combine the four 2x2 partial products at their digit weights.
  always_comb begin
    q_ll = mul2(x[1:0], y[1:0]);
    q_hl = mul2(x[3:2], y[1:0]);
    q_lh = mul2(x[1:0], y[3:2]);
    q_hh = mul2(x[3:2], y[3:2]);
    p    = {4'b0000, q_ll}
         + {2'b00, q_hl, 2'b00}
         + {2'b00, q_lh, 2'b00}
         + {q_hh, 4'b0000};
  end

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// rtl/vedic_mul_seq_ctrl.sv - digit-serial WIDTHxWIDTH multiplier sequencer around one multiply4x4 core (option: VEDIC_MUL_ZERO_SKIP_EN)
module vedic_mul_seq_ctrl
  import vedic_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int IW = idx_w(N);
  localparam int RW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [RW-1:0]      acc;
  logic [IW-1:0]      i_idx;
  logic [IW-1:0]      j_idx;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [PP_W-1:0]    pp;
  logic [RW-1:0]      pp_ext;
  logic [RW-1:0]      pp_shift;
  logic [RW-1:0]      sum;
  logic [IW:0]        dig_pos;

  logic               accept;
  logic               last_pair;
  logic               zero_op;

  multiply4x4 u_core (
    .x (a_dig),
    .y (b_dig),
    .p (pp)
  );

  // Select the current digit pair from the registered operands and form the weighted partial sum.
  always_comb begin
    a_dig    = DIGIT_W'(a_q >> {i_idx, 2'b00});
    b_dig    = DIGIT_W'(b_q >> {j_idx, 2'b00});
    pp_ext   = '0;
    pp_ext[PP_W-1:0] = pp;
    dig_pos  = {1'b0, i_idx} + {1'b0, j_idx};
    pp_shift = pp_ext << {dig_pos, 2'b00};
    sum      = acc + pp_shift;
  end

  // Handshake qualifiers and the optional zero-operand shortcut.
  always_comb begin
    accept    = in_valid && (state == IDLE);
    last_pair = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
`ifdef VEDIC_MUL_ZERO_SKIP_EN
    zero_op   = (a == '0) || (b == '0);
`else
    zero_op   = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_pair) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand capture, digit walk (j fastest) and accumulation; c updates only when a product completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      c     <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      if (zero_op) begin
        c <= '0;
      end
    end else if (state == CALC) begin
      acc <= sum;
      if (j_idx == LAST_IDX) begin
        j_idx <= '0;
        i_idx <= last_pair ? '0 : i_idx + 1'b1;
      end else begin
        j_idx <= j_idx + 1'b1;
      end
      if (last_pair) begin
        c <= sum;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// tb/tb_vedic_mul_seq_ctrl.sv - scoreboard bench for vedic_mul_seq_ctrl at WIDTH=8 and WIDTH=16 (honours VEDIC_MUL_ZERO_SKIP_EN)
module tb_vedic_mul_seq_ctrl;

`ifdef VEDIC_MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] c16;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [15:0] e8;
  logic [31:0] e16;

  vedic_mul_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .c         (c8),
    .busy      (busy8)
  );

  vedic_mul_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .out_valid (ov16),
    .out_ready (or16),
    .c         (c16),
    .busy      (busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        check("c8_unexpected", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("c8", c8, e8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov16 && or16) begin
      if (q16.size() == 0) begin
        check("c16_unexpected", 64'd1, 64'd0);
      end else begin
        e16 = q16.pop_front();
        check("c16", c16, e16);
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit keep, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    a8 = a;
    b8 = b;
    iv8 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ir8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept8_timeout", 64'd0, 64'd1);
      iv8 = 1'b0;
      return;
    end
    q8.push_back(16'(a) * 16'(b));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep) iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    a16 = a;
    b16 = b;
    iv16 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ir16) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept16_timeout", 64'd0, 64'd1);
      iv16 = 1'b0;
      return;
    end
    q16.push_back(32'(a) * 32'(b));
    @(posedge clk);
    #1;
    iv16 = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!ov8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov8) n = -1;
  endtask

  task automatic wait_valid16(output int n);
    n = 0;
    while (!ov16 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov16) n = -1;
  endtask

  initial begin
    #1_000_000;
    check("watchdog", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n;
    int t;
    int tb2b[3];
    logic [7:0] pa[3];
    logic [7:0] pb[3];

    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b0;

    @(negedge clk);
    check("rst_in_ready8", ir8, 1'b1);
    check("rst_out_valid8", ov8, 1'b0);
    check("rst_c8", c8, 16'h0000);
    check("rst_busy8", busy8, 1'b0);
    check("rst_in_ready16", ir16, 1'b1);
    check("rst_c16", c16, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FF x FF with consumer always ready
    or8 = 1'b1;
    send8(8'hFF, 8'hFF, 1'b0, t);
    check("busy_calc8", busy8, 1'b1);
    check("in_ready_calc8", ir8, 1'b0);
    wait_valid8(n);
    check("lat_ffff8", n, 64'd4);
    check("c8_ffff_direct", c8, 16'hFE01);
    @(posedge clk);
    #1;
    check("idle_after_done8", ir8, 1'b1);

    // 0D x B7 with consumer stalled for 10 cycles
    or8 = 1'b0;
    send8(8'h0D, 8'hB7, 1'b0, t);
    wait_valid8(n);
    check("lat_0db7", n, 64'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_c8", c8, 16'h094B);
      check("hold_out_valid8", ov8, 1'b1);
      check("hold_in_ready8", ir8, 1'b0);
    end
    @(posedge clk);
    #1;
    or8 = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle8", ir8, 1'b1);
    check("release_out_valid8", ov8, 1'b0);

    // back-to-back with in_valid held high
    pa[0] = 8'h12; pb[0] = 8'h34;
    pa[1] = 8'hAB; pb[1] = 8'hCD;
    pa[2] = 8'hFF; pb[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      send8(pa[k], pb[k], 1'b1, tb2b[k]);
    end
    iv8 = 1'b0;
    check("b2b_spacing01", tb2b[1] - tb2b[0], 64'd6);
    check("b2b_spacing12", tb2b[2] - tb2b[1], 64'd6);
    wait_valid8(n);
    check("lat_b2b_last", n, 64'd4);
    @(posedge clk);
    #1;
    check("b2b_drained8", q8.size(), 64'd0);

    // asynchronous reset in the middle of a calculation
    send8(8'hFF, 8'hFF, 1'b0, t);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready8", ir8, 1'b1);
    check("abort_out_valid8", ov8, 1'b0);
    check("abort_c8", c8, 16'h0000);
    check("abort_busy8", busy8, 1'b0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero operand
    send8(8'h00, 8'h5A, 1'b0, t);
    wait_valid8(n);
    check("lat_zero8", n, ZLAT);
    check("c8_zero_direct", c8, 16'h0000);
    @(posedge clk);
    #1;

    // WIDTH=16 corner and random sweep
    or16 = 1'b1;
    send16(16'hFFFF, 16'hFFFF);
    wait_valid16(n);
    check("lat_ffff16", n, 64'd16);
    check("c16_ffff_direct", c16, 32'hFFFE0001);
    @(posedge clk);
    #1;
    for (int k = 0; k < 1000; k++) begin
      send16(16'($urandom), 16'($urandom));
    end
    repeat (40) @(posedge clk);
    #1;
    check("drained16", q16.size(), 64'd0);
    check("drained8", q8.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
